// File: rtl/mips_wb_arbiter.sv
// Register-file write-port arbiter: the pipeline writeback port shares the
// register file with a 2-entry result FIFO fed by the multi-cycle unit.
module mips_wb_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        WB_VALID,
    input  logic [4:0]  WB_REG,
    input  logic [31:0] WB_DATA,
    input  logic        MDU_VALID,
    output logic        MDU_READY,
    input  logic [4:0]  MDU_REG,
    input  logic [31:0] MDU_DATA,
    input  logic        ISSUE_VALID,
    input  logic [4:0]  ISSUE_REG,
    input  logic [4:0]  CHK_REG1,
    input  logic [4:0]  CHK_REG2,
    output logic        STALL,
    output logic        HOLD,
    output logic        ERR,
    output logic [1:0]  FIFO_COUNT,
    output logic        RegWrite,
    output logic [4:0]  WriteReg,
    output logic [31:0] WriteData
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t        fifo_q [2];
    logic [1:0]    count_q, count_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic          wr_idx;
    entry_t        head;

    logic          push, pop, grant;
    logic [4:0]    grant_reg;
    logic [31:0]   grant_data;

    logic [31:0]   pend_q, pend_d;
    logic [CW-1:0] starve_q, starve_d;
    logic          hold_q, hold_d;
    logic          err_q, err_d;

    logic          regwrite_q, regwrite_d;
    logic [4:0]    wreg_q, wreg_d;
    logic [31:0]   wdata_q, wdata_d;

    // Handshake and arbitration; a freshly pushed entry only becomes visible
    // through count_q on the next cycle, so it cannot drain in the push cycle.
    always_comb begin
        MDU_READY  = (count_q != 2'd2);
        push       = MDU_VALID && MDU_READY;
        pop        = !WB_VALID && (count_q != 2'd0);
        grant      = WB_VALID || pop;
        head       = fifo_q[rd_ptr_q];
        wr_idx     = rd_ptr_q ^ count_q[0];
        grant_reg  = WB_VALID ? WB_REG  : head.rd;
        grant_data = WB_VALID ? WB_DATA : head.data;
    end

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        if (push && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push) begin
            count_d = count_q - 2'd1;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
    end

    // Clear is applied before set so an issue to the same register wins.
    always_comb begin
        pend_d = pend_q;
        if (pop) begin
            pend_d[head.rd] = 1'b0;
        end
        if (ISSUE_VALID && (ISSUE_REG != 5'd0)) begin
            pend_d[ISSUE_REG] = 1'b1;
        end
    end

    always_comb begin
        STALL = ((CHK_REG1 != 5'd0) && pend_q[CHK_REG1]) ||
                ((CHK_REG2 != 5'd0) && pend_q[CHK_REG2]);
    end

    always_comb begin
        starve_d = starve_q;
        if (pop || (count_q == 2'd0)) begin
            starve_d = '0;
        end else if (WB_VALID && (starve_q != LIMIT)) begin
            starve_d = starve_q + CW'(1);
        end
        hold_d = pop ? 1'b0 : (hold_q || (starve_d == LIMIT));
        err_d  = err_q || (WB_VALID && hold_q);
    end

    // Writes to register 0 are consumed but never reach the register file.
    always_comb begin
        regwrite_d = grant && (grant_reg != 5'd0);
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        if (regwrite_d) begin
            wreg_d  = grant_reg;
            wdata_d = grant_data;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fifo_q[0] <= '0;
            fifo_q[1] <= '0;
        end else if (push) begin
            fifo_q[wr_idx] <= '{rd: MDU_REG, data: MDU_DATA};
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count_q    <= 2'd0;
            rd_ptr_q   <= 1'b0;
            pend_q     <= '0;
            starve_q   <= '0;
            hold_q     <= 1'b0;
            err_q      <= 1'b0;
            regwrite_q <= 1'b0;
            wreg_q     <= 5'd0;
            wdata_q    <= 32'd0;
        end else begin
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            pend_q     <= pend_d;
            starve_q   <= starve_d;
            hold_q     <= hold_d;
            err_q      <= err_d;
            regwrite_q <= regwrite_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
        end
    end

    assign FIFO_COUNT = count_q;
    assign HOLD       = hold_q;
    assign ERR        = err_q;
    assign RegWrite   = regwrite_q;
    assign WriteReg   = wreg_q;
    assign WriteData  = wdata_q;

endmodule

// File: tb/tb_mips_wb_arbiter.sv
// Bench for mips_wb_arbiter: fixed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_mips_wb_arbiter;

    localparam int LIMIT = 4;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        WB_VALID;
    logic [4:0]  WB_REG;
    logic [31:0] WB_DATA;
    logic        MDU_VALID;
    logic        MDU_READY;
    logic [4:0]  MDU_REG;
    logic [31:0] MDU_DATA;
    logic        ISSUE_VALID;
    logic [4:0]  ISSUE_REG;
    logic [4:0]  CHK_REG1;
    logic [4:0]  CHK_REG2;
    logic        STALL;
    logic        HOLD;
    logic        ERR;
    logic [1:0]  FIFO_COUNT;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;

    always #5 CLK = ~CLK;

    mips_wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .WB_VALID(WB_VALID), .WB_REG(WB_REG), .WB_DATA(WB_DATA),
        .MDU_VALID(MDU_VALID), .MDU_READY(MDU_READY),
        .MDU_REG(MDU_REG), .MDU_DATA(MDU_DATA),
        .ISSUE_VALID(ISSUE_VALID), .ISSUE_REG(ISSUE_REG),
        .CHK_REG1(CHK_REG1), .CHK_REG2(CHK_REG2),
        .STALL(STALL), .HOLD(HOLD), .ERR(ERR), .FIFO_COUNT(FIFO_COUNT),
        .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData)
    );

    int vecCount  = 0;
    int missCount = 0;

    // Reference model: FIFO as a queue, scoreboard as a bit array.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    ent_t        mq[$];
    bit          mPend[32];
    int          mStarve;
    bit          mHold, mErr, mRw;
    logic [4:0]  mWr;
    logic [31:0] mWd;

    typedef struct {
        logic wbV; logic [4:0] wbR; logic [31:0] wbD;
        logic mdV; logic [4:0] mdR; logic [31:0] mdD;
        logic isV; logic [4:0] isR;
        logic [4:0] c1; logic [4:0] c2;
        logic eRw; logic [4:0] eWr; logic [31:0] eWd;
        logic eRdy; logic [1:0] eCnt; logic eStall;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(
        input logic wbV, input logic [4:0] wbR, input logic [31:0] wbD,
        input logic mdV, input logic [4:0] mdR, input logic [31:0] mdD,
        input logic isV, input logic [4:0] isR,
        input logic [4:0] c1, input logic [4:0] c2,
        input logic eRw, input logic [4:0] eWr, input logic [31:0] eWd,
        input logic eRdy, input logic [1:0] eCnt, input logic eStall);
        vec_t v;
        v.wbV = wbV; v.wbR = wbR; v.wbD = wbD;
        v.mdV = mdV; v.mdR = mdR; v.mdD = mdD;
        v.isV = isV; v.isR = isR; v.c1 = c1; v.c2 = c2;
        v.eRw = eRw; v.eWr = eWr; v.eWd = eWd;
        v.eRdy = eRdy; v.eCnt = eCnt; v.eStall = eStall;
        return v;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecCount++;
        if (act !== exp) begin
            missCount++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic modelReset();
        mq.delete();
        foreach (mPend[i]) mPend[i] = 1'b0;
        mStarve = 0;
        mHold = 1'b0;
        mErr = 1'b0;
        mRw = 1'b0;
        mWr = 5'd0;
        mWd = 32'd0;
    endtask

    task automatic drive(input logic wbV, input logic [4:0] wbR, input logic [31:0] wbD,
                         input logic mdV, input logic [4:0] mdR, input logic [31:0] mdD,
                         input logic isV, input logic [4:0] isR,
                         input logic [4:0] c1, input logic [4:0] c2);
        WB_VALID = wbV; WB_REG = wbR; WB_DATA = wbD;
        MDU_VALID = mdV; MDU_REG = mdR; MDU_DATA = mdD;
        ISSUE_VALID = isV; ISSUE_REG = isR;
        CHK_REG1 = c1; CHK_REG2 = c2;
    endtask

    task automatic checkOutput();
        bit stallExp;
        stallExp = ((CHK_REG1 != 5'd0) && mPend[CHK_REG1]) ||
                   ((CHK_REG2 != 5'd0) && mPend[CHK_REG2]);
        checkValue("MDU_READY", 32'(MDU_READY), 32'(mq.size() < 2));
        checkValue("FIFO_COUNT", 32'(FIFO_COUNT), 32'(mq.size()));
        checkValue("STALL", 32'(STALL), 32'(stallExp));
        checkValue("HOLD", 32'(HOLD), 32'(mHold));
        checkValue("ERR", 32'(ERR), 32'(mErr));
        checkValue("RegWrite", 32'(RegWrite), 32'(mRw));
        if (mRw) begin
            checkValue("WriteReg", 32'(WriteReg), 32'(mWr));
            checkValue("WriteData", WriteData, mWd);
        end
    endtask

    // One clock edge of the arbiter rules applied to the model.
    task automatic modelStep();
        bit push, pop, grant;
        logic [4:0]  gr;
        logic [31:0] gd;
        int ns;
        push = MDU_VALID && (mq.size() < 2);
        pop  = !WB_VALID && (mq.size() > 0);
        grant = WB_VALID || pop;
        gr = 5'd0;
        gd = 32'd0;
        if (WB_VALID) begin
            gr = WB_REG; gd = WB_DATA;
        end else if (pop) begin
            gr = mq[0].rd; gd = mq[0].data;
        end
        mErr = mErr || (WB_VALID && mHold);
        if (pop || mq.size() == 0) ns = 0;
        else if (WB_VALID) ns = (mStarve + 1 > LIMIT) ? LIMIT : mStarve + 1;
        else ns = mStarve;
        mHold = pop ? 1'b0 : (mHold || ns == LIMIT);
        mStarve = ns;
        if (pop) begin
            mPend[mq[0].rd] = 1'b0;
            void'(mq.pop_front());
        end
        if (ISSUE_VALID && ISSUE_REG != 5'd0) mPend[ISSUE_REG] = 1'b1;
        if (push) mq.push_back('{rd: MDU_REG, data: MDU_DATA});
        mRw = grant && (gr != 5'd0);
        if (mRw) begin
            mWr = gr; mWd = gd;
        end
    endtask

    task automatic applyStimulus(input logic wbV, input logic [4:0] wbR, input logic [31:0] wbD,
                                 input logic mdV, input logic [4:0] mdR, input logic [31:0] mdD,
                                 input logic isV, input logic [4:0] isR,
                                 input logic [4:0] c1, input logic [4:0] c2);
        @(negedge CLK);
        drive(wbV, wbR, wbD, mdV, mdR, mdD, isV, isR, c1, c2);
        #1;
        checkOutput();
        modelStep();
    endtask

    task automatic doReset();
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        RST_N = 1'b0;
        #2;
        RST_N = 1'b1;
        modelReset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        tbl[0]  = mk(1, 5, 32'hA5A5A5A5, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0,            1, 0, 0);
        tbl[1]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0,   1, 5, 32'hA5A5A5A5, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0,   0, 0, 0,            1, 0, 0);
        tbl[3]  = mk(0, 0, 0,            0, 0, 0, 1, 8, 0, 0,   0, 0, 0,            1, 0, 0);
        tbl[4]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 8, 0,   0, 0, 0,            1, 0, 1);
        tbl[5]  = mk(0, 0, 0,            1, 8, 32'h12345678, 0, 0, 8, 0, 0, 0, 0,   1, 0, 1);
        tbl[6]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 8, 0,   0, 0, 0,            1, 1, 1);
        tbl[7]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 8, 0,   1, 8, 32'h12345678, 1, 0, 0);
        tbl[8]  = mk(1, 0, 32'hFFFFFFFF, 1, 0, 1, 0, 0, 0, 0,   0, 0, 0,            1, 0, 0);
        tbl[9]  = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0,   0, 0, 0,            1, 1, 0);
        tbl[10] = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 0,   0, 0, 0,            1, 0, 0);
        tbl[11] = mk(1, 3, 32'h33,       0, 0, 0, 0, 0, 0, 3,   0, 0, 0,            1, 0, 0);
        tbl[12] = mk(0, 0, 0,            0, 0, 0, 1, 31, 0, 31, 1, 3, 32'h33,       1, 0, 0);
        tbl[13] = mk(0, 0, 0,            1, 31, 32'h31, 0, 0, 0, 31, 0, 0, 0,       1, 0, 1);
        tbl[14] = mk(0, 0, 0,            0, 0, 0, 1, 31, 0, 31, 0, 0, 0,            1, 1, 1);
        tbl[15] = mk(0, 0, 0,            0, 0, 0, 0, 0, 0, 31,  1, 31, 32'h31,      1, 0, 1);

        // Reset state, with a nonzero check register to prove STALL is clear.
        RST_N = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 8, 9);
        modelReset();
        repeat (2) @(negedge CLK);
        #1;
        checkValue("rst RegWrite", 32'(RegWrite), 0);
        checkValue("rst WriteReg", 32'(WriteReg), 0);
        checkValue("rst WriteData", WriteData, 0);
        checkValue("rst FIFO_COUNT", 32'(FIFO_COUNT), 0);
        checkValue("rst MDU_READY", 32'(MDU_READY), 1);
        checkValue("rst STALL", 32'(STALL), 0);
        checkValue("rst HOLD", 32'(HOLD), 0);
        checkValue("rst ERR", 32'(ERR), 0);
        RST_N = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            drive(tbl[i].wbV, tbl[i].wbR, tbl[i].wbD, tbl[i].mdV, tbl[i].mdR, tbl[i].mdD,
                  tbl[i].isV, tbl[i].isR, tbl[i].c1, tbl[i].c2);
            #1;
            checkValue($sformatf("tbl%0d RegWrite", i), 32'(RegWrite), 32'(tbl[i].eRw));
            if (tbl[i].eRw) begin
                checkValue($sformatf("tbl%0d WriteReg", i), 32'(WriteReg), 32'(tbl[i].eWr));
                checkValue($sformatf("tbl%0d WriteData", i), WriteData, tbl[i].eWd);
            end
            checkValue($sformatf("tbl%0d MDU_READY", i), 32'(MDU_READY), 32'(tbl[i].eRdy));
            checkValue($sformatf("tbl%0d FIFO_COUNT", i), 32'(FIFO_COUNT), 32'(tbl[i].eCnt));
            checkValue($sformatf("tbl%0d STALL", i), 32'(STALL), 32'(tbl[i].eStall));
            checkValue($sformatf("tbl%0d HOLD", i), 32'(HOLD), 0);
            checkValue($sformatf("tbl%0d ERR", i), 32'(ERR), 0);
        end

        // Back-pressure: three results while WB owns the port.
        doReset();
        applyStimulus(1, 1, 32'h1111, 1, 10, 32'hE1, 0, 0, 0, 0);
        applyStimulus(1, 2, 32'h2222, 1, 11, 32'hE2, 0, 0, 0, 0);
        applyStimulus(1, 3, 32'h3333, 1, 12, 32'hE3, 0, 0, 0, 0);
        checkValue("s3 FIFO_COUNT full", 32'(FIFO_COUNT), 2);
        checkValue("s3 MDU_READY low", 32'(MDU_READY), 0);
        applyStimulus(0, 0, 0, 1, 12, 32'hE3, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 12, 32'hE3, 0, 0, 0, 0);
        checkValue("s3 first drain reg", 32'(WriteReg), 10);
        idle(4);
        checkValue("s3 drained", 32'(FIFO_COUNT), 0);

        // Starvation: HOLD after LIMIT blocked cycles, ERR on WB under HOLD.
        doReset();
        applyStimulus(0, 0, 0, 1, 9, 32'h9999, 0, 0, 0, 0);
        for (int i = 0; i < LIMIT; i++) applyStimulus(1, 4, 32'h4000 + i, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 6, 32'h6666, 0, 0, 0, 0, 0, 0, 0);
        checkValue("s4 HOLD set", 32'(HOLD), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("s4 ERR set", 32'(ERR), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkValue("s4 HOLD cleared", 32'(HOLD), 0);
        checkValue("s4 ERR sticky", 32'(ERR), 1);
        checkValue("s4 drain reg", 32'(WriteReg), 9);

        // Asynchronous reset mid-drain with a full FIFO and HOLD asserted.
        doReset();
        applyStimulus(0, 0, 0, 1, 20, 32'hAAAA, 1, 20, 0, 0);
        applyStimulus(1, 7, 32'h7777, 1, 21, 32'hBBBB, 0, 0, 0, 0);
        for (int i = 0; i < LIMIT - 1; i++) applyStimulus(1, 7, 32'h7770 + i, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 20, 0);
        #1;
        checkValue("s6 pre FIFO_COUNT", 32'(FIFO_COUNT), 2);
        checkValue("s6 pre HOLD", 32'(HOLD), 1);
        checkValue("s6 pre STALL", 32'(STALL), 1);
        #1;
        RST_N = 1'b0;
        #1;
        checkValue("s6 RegWrite", 32'(RegWrite), 0);
        checkValue("s6 WriteReg", 32'(WriteReg), 0);
        checkValue("s6 WriteData", WriteData, 0);
        checkValue("s6 FIFO_COUNT", 32'(FIFO_COUNT), 0);
        checkValue("s6 MDU_READY", 32'(MDU_READY), 1);
        checkValue("s6 STALL", 32'(STALL), 0);
        checkValue("s6 HOLD", 32'(HOLD), 0);
        checkValue("s6 ERR", 32'(ERR), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        modelReset();
        idle(4);

        // Randomized traffic in phases of differing writeback pressure.
        doReset();
        for (int blk = 0; blk < 12; blk++) begin
            int wbPct;
            wbPct = (blk % 3 == 0) ? 15 : ((blk % 3 == 1) ? 55 : 92);
            for (int i = 0; i < 50; i++) begin
                applyStimulus($urandom_range(0, 99) < wbPct, 5'($urandom_range(0, 7)), $urandom,
                              $urandom_range(0, 99) < 60, 5'($urandom_range(0, 7)), $urandom,
                              $urandom_range(0, 99) < 30, 5'($urandom_range(0, 7)),
                              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            end
        end
        idle(4);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/mips_wb_arbiter.md
MIPS_WB_ARBITER -- requirements
Module: mips_wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4: consecutive blocked cycles before HOLD asserts.
REQ-002 SHALL have ports in this order:
- CLK  in  1  sole clock, rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- WB_VALID  in  1  pipeline writeback request.
- WB_REG  in  5  pipeline writeback destination.
- WB_DATA  in  32  pipeline writeback data.
- MDU_VALID  in  1  multi-cycle unit result valid.
- MDU_READY  out  1  result accepted when high.
- MDU_REG  in  5  multi-cycle unit result destination.
- MDU_DATA  in  32  multi-cycle unit result data.
- ISSUE_VALID  in  1  multi-cycle op issued.
- ISSUE_REG  in  5  destination of the issued op.
- CHK_REG1  in  5  decode source register 1.
- CHK_REG2  in  5  decode source register 2.
- STALL  out  1  source has a pending write.
- HOLD  out  1  pipeline must not assert WB_VALID.
- ERR  out  1  sticky protocol-violation flag.
- FIFO_COUNT  out  2  buffered result count, 0..2.
- RegWrite  out  1  register file write enable.
- WriteReg  out  5  register file write address.
- WriteData  out  32  register file write data.

Function
REQ-003 SHALL buffer multi-cycle results in a 2-entry FIFO; MDU_READY = (FIFO_COUNT < 2), combinational.
REQ-004 SHALL push on MDU_VALID && MDU_READY; a pushed entry is eligible to drain no earlier than the next cycle.
REQ-005 SHALL grant the write port each cycle: WB_VALID wins; else FIFO head pops if FIFO_COUNT > 0; else idle.
REQ-006 SHALL register RegWrite/WriteReg/WriteData one cycle after grant (latency 1); RegWrite is a one-cycle pulse per granted write.
REQ-007 SHALL drop any granted write whose register is 0: RegWrite stays 0, the request is still consumed (FIFO pops).
REQ-008 SHALL update FIFO_COUNT by +1 push only, -1 pop only, unchanged on simultaneous push and pop.
REQ-009 SHALL keep a 32-bit pending scoreboard:
- Set bit ISSUE_REG on ISSUE_VALID when ISSUE_REG != 0.
- Clear bit MDU_REG when that FIFO entry pops.
- Set wins when set and clear hit the same bit in one cycle.
REQ-010 SHALL drive STALL combinationally high when CHK_REG1 or CHK_REG2 is nonzero with its pending bit set.
REQ-011 SHALL run a starvation counter:
- Increment when FIFO_COUNT > 0 and WB_VALID = 1.
- Reset to 0 when the FIFO pops or is empty.
- Saturate at STARVE_LIMIT.
REQ-012 SHALL register HOLD = 1 the cycle after the counter reaches STARVE_LIMIT and clear it the cycle after the next FIFO pop.
REQ-013 SHALL keep WB priority when WB_VALID = 1 while HOLD = 1, and set ERR, which stays 1 until reset.
REQ-014 SHALL ignore MDU_VALID when MDU_READY = 0 and hold all FIFO contents unchanged.

Reset
REQ-015 SHALL, while RST_N = 0, immediately force: RegWrite 0, WriteReg 0, WriteData 0, FIFO empty, FIFO_COUNT 0, scoreboard clear, counter 0, HOLD 0, ERR 0.
REQ-016 SHALL drive MDU_READY = 1 and STALL = 0 during reset, since both derive from reset state.
REQ-017 SHALL discard in-flight FIFO entries and pending bits on reset mid-operation, with no RegWrite pulse after reset asserts.

Verification
REQ-018 Scenario 1: WB_VALID=1, WB_REG=5, WB_DATA=0xA5A5A5A5 for one cycle -> next cycle RegWrite=1, WriteReg=5, WriteData=0xA5A5A5A5; following cycle RegWrite=0.
REQ-019 Scenario 2: ISSUE_VALID with ISSUE_REG=8, then CHK_REG1=8 -> STALL=1; MDU result reg 8 = 0x12345678 pushed while WB idle -> written 2 cycles after push; STALL=0 the cycle after the pop.
REQ-020 Scenario 3: three back-to-back MDU pushes with WB_VALID held 1 -> FIFO_COUNT=2, MDU_READY=0, third result held by the producer; after WB drops, two writes occur in FIFO order, then the third is accepted.
REQ-021 Scenario 4: FIFO nonempty with WB_VALID=1 for 4 cycles (STARVE_LIMIT=4) -> HOLD=1; WB_VALID kept 1 -> ERR=1; WB_VALID dropped -> pop, HOLD=0 the next cycle, ERR stays 1.
REQ-022 Scenario 5: WB_REG=0 with WB_VALID=1, and MDU result to reg 0 -> no RegWrite pulse, FIFO_COUNT returns to 0.
REQ-023 Scenario 6: RST_N low mid-drain with FIFO_COUNT=2 and HOLD=1 -> all outputs reset without waiting for a clock edge; no write after RST_N rises.
